// File: rtl/counter_32b.sv
// counter_32b: 32-bit multi-mode counter (up 1, down 1, down 3, parallel load)
// built from a chain of 4-bit slices that ripple a carry/borrow combinationally.

// One slice: adds or subtracts the incoming carry/borrow from its nibble and
// reports the carry/borrow leaving its top bit. The incoming value is two bits
// wide so the lowest slice can take the step of 3 directly.
module counter_32b_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] q,
  input  logic [1:0]   carry_in,
  input  logic         down,
  output logic [W-1:0] q_next,
  output logic         carry_out
);

  logic [W:0] ext_q;
  logic [W:0] ext_c;
  logic [W:0] result;

  // Extend by one bit so the carry (up) or borrow (down) lands in the MSB
  always_comb begin
    ext_q = {1'b0, q};
    ext_c = (W+1)'(carry_in);
    if (down) begin
      result = ext_q - ext_c;
    end else begin
      result = ext_q + ext_c;
    end
    q_next    = result[W-1:0];
    carry_out = result[W];
  end

endmodule

// Top level: selects the step and direction, cascades the slices and
// registers the count together with the wrap and load pulses.
module counter_32b #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_,
  input  logic [1:0]       mode_,
  input  logic [WIDTH-1:0] D_,
  output logic [WIDTH-1:0] Q_,
  output logic             rco_,
  output logic             load_
);

  localparam int NUM_SLICES = WIDTH / SLICE;

  typedef enum logic [1:0] {
    MODE_UP    = 2'b00,
    MODE_DOWN  = 2'b01,
    MODE_DOWN3 = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_t;

  mode_t                 mode;
  logic [1:0]            step;
  logic                  down;
  logic [WIDTH-1:0]      next_q;
  logic [NUM_SLICES-1:0] slice_cout;

  // Decode the operation into a step size and a direction for the cascade
  always_comb begin
    mode = mode_t'(mode_);
    step = 2'd1;
    down = 1'b0;
    case (mode)
      MODE_UP:    begin step = 2'd1; down = 1'b0; end
      MODE_DOWN:  begin step = 2'd1; down = 1'b1; end
      MODE_DOWN3: begin step = 2'd3; down = 1'b1; end
      default:    begin step = 2'd1; down = 1'b0; end
    endcase
  end

  // Slice 0 takes the step; every higher slice takes the lower slice's carry/borrow
  for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
    logic [1:0] cin;
    if (i == 0) begin : g_first
      assign cin = step;
    end else begin : g_rest
      assign cin = {1'b0, slice_cout[i-1]};
    end

    counter_32b_slice #(
      .W(SLICE)
    ) u_slice (
      .q         (Q_[i*SLICE +: SLICE]),
      .carry_in  (cin),
      .down      (down),
      .q_next    (next_q[i*SLICE +: SLICE]),
      .carry_out (slice_cout[i])
    );
  end

  // Register the count and single-cycle rco/load pulses; reset clears all at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q_    <= '0;
      rco_  <= 1'b0;
      load_ <= 1'b0;
    end else if (!enable_) begin
      rco_  <= 1'b0;
      load_ <= 1'b0;
    end else if (mode == MODE_LOAD) begin
      Q_    <= D_;
      rco_  <= 1'b0;
      load_ <= 1'b1;
    end else begin
      Q_    <= next_q;
      rco_  <= slice_cout[NUM_SLICES-1];
      load_ <= 1'b0;
    end
  end

endmodule
